// File: rtl/xadc_seq_pkg.sv
// Shared constants for the XADC sequence reader: FSM encoding, DRP addresses
// and the 12-bit result formatter.
package xadc_seq_pkg;

  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_WAIT_EOS  = 2'd1;
  localparam logic [1:0] ST_WAIT_DRDY = 2'd2;
  localparam logic [1:0] ST_PUBLISH   = 2'd3;

  localparam logic [6:0] ADDR_VPVN  = 7'h03;
  localparam logic [6:0] ADDR_VAUX0 = 7'h10;
  localparam logic [6:0] ADDR_VAUX8 = 7'h18;
  localparam logic [6:0] ADDR_CFG0  = 7'h40;

  // XADC conversion results are left-justified in the 16-bit DO word.
  function automatic logic [11:0] fmt12(input logic [15:0] d);
    return d[15:4];
  endfunction

endpackage

// File: rtl/xadc_seq_reader.sv
// DRP master that reads NUM_CH XADC result registers after each end-of-sequence
// and publishes the frame with a FIFO strobe. Optional: XADC_SEQ_DRDY_TIMEOUT_EN.
module xadc_seq_reader
  import xadc_seq_pkg::*;
#(
  parameter int                  NUM_CH      = 2,
  parameter logic [NUM_CH*7-1:0] CH_ADDRS    = {ADDR_VAUX8, ADDR_VAUX0},
  parameter int                  SAMPLE_W    = 16,
  parameter int                  DECIM       = 1,
  parameter int                  TIMEOUT_CYC = 1024
) (
  input  logic                         DCLK,
  input  logic                         RESET_N,
  input  logic                         BUSY,
  input  logic                         EOS,
  input  logic                         DRDY,
  input  logic [15:0]                  DO,
  input  logic                         CLR_FLAGS,
  output logic [6:0]                   DADDR,
  output logic                         DEN,
  output logic                         DWE,
  output logic [15:0]                  DI,
  output logic [NUM_CH*SAMPLE_W-1:0]   SAMPLES,
  output logic                         FIFO_EN,
  output logic                         OVERRUN,
  output logic                         TIMEOUT
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [15:0]      DEC_LAST = 16'(DECIM - 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..16");
  end
  if (SAMPLE_W != 12 && SAMPLE_W != 16) begin : g_bad_sample_w
    $error("SAMPLE_W must be 12 or 16");
  end
  if (DECIM < 1 || DECIM > 65535) begin : g_bad_decim
    $error("DECIM must be in 1..65535");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout_cyc
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  logic [1:0]                 state;
  logic [IDX_W-1:0]           slot_idx;
  logic [IDX_W-1:0]           next_idx;
  logic [15:0]                dec_cnt;
  logic                       eos_pending;
  logic                       start;
  logic                       to_fire;
  logic [SAMPLE_W-1:0]        sample_fmt;
  logic [NUM_CH*SAMPLE_W-1:0] shadow;
  logic [NUM_CH*SAMPLE_W-1:0] frame_next;

  assign DWE = 1'b0;
  assign DI  = 16'h0000;

  assign start    = (state == ST_WAIT_EOS) && (eos_pending || EOS);
  assign next_idx = slot_idx + IDX_W'(1);

  if (SAMPLE_W == 12) begin : g_fmt12
    assign sample_fmt = fmt12(DO);
  end else begin : g_fmt16
    assign sample_fmt = DO;
  end

  // NOTE: give every always_comb output a full default before any partial
  // update so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    frame_next = shadow;
    frame_next[SAMPLE_W*slot_idx +: SAMPLE_W] = sample_fmt;
  end

  // NOTE: the shadow frame is storage, not control, so it carries no reset;
  // every slot is rewritten before a frame can be published.
  always_ff @(posedge DCLK) begin
    if (state == ST_WAIT_DRDY && DRDY) shadow <= frame_next;
  end

  // Publication is decided on the last DRDY so FIFO_EN and SAMPLES are both
  // registered and valid during the PUBLISH cycle itself.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge DCLK) begin
    if (!RESET_N) begin
      state       <= ST_INIT;
      DEN         <= 1'b0;
      FIFO_EN     <= 1'b0;
      OVERRUN     <= 1'b0;
      DADDR       <= '0;
      SAMPLES     <= '0;
      slot_idx    <= '0;
      dec_cnt     <= '0;
      eos_pending <= 1'b0;
    end else begin
      DEN         <= 1'b0;
      FIFO_EN     <= 1'b0;
      // An EOS landing in the same cycle a pending frame starts is a new event.
      eos_pending <= start ? (eos_pending & EOS) : (eos_pending | EOS);

      if (EOS && (state == ST_WAIT_DRDY || state == ST_PUBLISH)) OVERRUN <= 1'b1;
      else if (CLR_FLAGS)                                        OVERRUN <= 1'b0;

      case (state)
        ST_INIT: begin
          if (!BUSY) state <= ST_WAIT_EOS;
        end
        ST_WAIT_EOS: begin
          if (start) begin
            slot_idx <= '0;
            DADDR    <= CH_ADDRS[6:0];
            DEN      <= 1'b1;
            state    <= ST_WAIT_DRDY;
          end
        end
        ST_WAIT_DRDY: begin
          if (DRDY) begin
            if (slot_idx != LAST_IDX) begin
              slot_idx <= next_idx;
              DADDR    <= CH_ADDRS[7*next_idx +: 7];
              DEN      <= 1'b1;
            end else begin
              state <= ST_PUBLISH;
              if (dec_cnt == DEC_LAST) begin
                SAMPLES <= frame_next;
                FIFO_EN <= 1'b1;
                dec_cnt <= '0;
              end else begin
                dec_cnt <= dec_cnt + 16'd1;
              end
            end
          end else if (to_fire) begin
            state <= ST_WAIT_EOS;
          end
        end
        default: begin
          state <= ST_WAIT_EOS;
        end
      endcase
    end
  end

`ifdef XADC_SEQ_DRDY_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt;

  assign to_fire = (state == ST_WAIT_DRDY) && !DRDY && (to_cnt == TO_LAST);

  // The count is held at zero outside WAIT_DRDY and on every DRDY, so it
  // restarts with each DEN.
  always_ff @(posedge DCLK) begin
    if (!RESET_N) begin
      to_cnt  <= '0;
      TIMEOUT <= 1'b0;
    end else begin
      to_cnt <= (state != ST_WAIT_DRDY || DRDY) ? 16'd0 : to_cnt + 16'd1;
      if (to_fire)        TIMEOUT <= 1'b1;
      else if (CLR_FLAGS) TIMEOUT <= 1'b0;
    end
  end
`else
  assign to_fire = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/xadc_seq_reader.md
Name: xadc_seq_reader

Overview:
- Parametrised successor to the two-channel XADC controller: a DRP master that, after each XADC end-of-sequence, reads NUM_CH result registers from a configurable address list.
- Publishes the complete frame atomically with a one-cycle FIFO write strobe.
- Adds per-frame decimation, 12/16-bit result formatting and a sticky overrun flag.
- Sits between the XADC primitive (instantiated by the parent) and the sample FIFO in trigger_acquire.

Parameters:
- NUM_CH, 2, number of channels read per frame (1..16).
- CH_ADDRS, {7'h18,7'h10}, packed NUM_CH*7-bit DRP address list; slot i = bits [7i+6:7i]; default reads VAUX0 then VAUX8.
- SAMPLE_W, 16, 16 = raw DO word; 12 = DO[15:4] right-aligned.
- DECIM, 1, emit one frame per DECIM completed frames (1..65535).
- TIMEOUT_CYC, 1024, DRDY wait limit; used only with the optional feature.

Ports:
- DCLK  in  1  DRP clock; the only clock.
- RESET_N  in  1  synchronous active-low reset.
- BUSY  in  1  XADC BUSY.
- EOS  in  1  XADC end-of-sequence pulse.
- DRDY  in  1  XADC DRP data ready.
- DO  in  16  XADC DRP read data.
- CLR_FLAGS  in  1  one-cycle clear of OVERRUN and TIMEOUT.
- DADDR  out  7  DRP address.
- DEN  out  1  DRP enable, one-cycle pulse.
- DWE  out  1  tied 0; reads only.
- DI  out  16  tied 0.
- SAMPLES  out  NUM_CH*SAMPLE_W  last published frame; slot i at [SAMPLE_W*i +: SAMPLE_W].
- FIFO_EN  out  1  one-cycle strobe; SAMPLES is valid in the same cycle.
- OVERRUN  out  1  sticky; EOS arrived while a frame was being read.
- TIMEOUT  out  1  sticky DRDY timeout; tied 0 without the optional feature.

Behaviour:
- Reset (RESET_N low at a DCLK edge):
  - State goes to INIT.
  - DEN, FIFO_EN, OVERRUN, TIMEOUT, DADDR, SAMPLES, slot index, decimation count and eos_pending all go to 0.
  - Reset mid-read abandons the frame; a late DRDY is ignored in INIT and WAIT_EOS.
- Registered outputs only: no combinational path from any input to any output.
- eos_pending:
  - Set on any cycle with EOS=1.
  - Cleared when a frame starts.
  - EOS and start in the same cycle leaves it set.
- States:
  - INIT: DEN=0; go to WAIT_EOS on the first cycle BUSY=0.
  - WAIT_EOS:
    - If eos_pending or EOS: clear pending, set index=0, DADDR=slot 0, DEN=1 for one cycle, go to WAIT_DRDY.
    - Latency: EOS high at cycle t gives DEN high at cycle t+1.
  - WAIT_DRDY:
    - DEN=0.
    - On DRDY=1, format DO into shadow slot index.
    - If index<NUM_CH-1: index++, next cycle DADDR=next slot with DEN=1, stay.
    - Else go to PUBLISH.
  - PUBLISH (one cycle):
    - If decimation count==DECIM-1: copy shadow to SAMPLES, FIFO_EN=1 this cycle, count=0.
    - Else count++, SAMPLES unchanged, FIFO_EN=0.
    - Then go to WAIT_EOS.
    - Back-to-back EOS restarts the next cycle.
- EOS in WAIT_DRDY or PUBLISH sets OVERRUN and eos_pending.
  - The current frame completes normally; the next frame starts immediately on return to WAIT_EOS.
  - Multiple EOS events collapse into one pending frame.
- CLR_FLAGS clears the flags; a set event in the same cycle wins.
- DRDY outside WAIT_DRDY is ignored.
- DEN is never asserted while a read is outstanding.

Optional Feature:
- XADC_SEQ_DRDY_TIMEOUT_EN defined:
  - 16-bit counter runs in WAIT_DRDY and resets on each DEN.
  - If TIMEOUT_CYC cycles pass without DRDY: set TIMEOUT, discard the frame, go to WAIT_EOS.
  - No FIFO_EN, SAMPLES and decimation count unchanged.
- Undefined: WAIT_DRDY waits indefinitely; TIMEOUT constant 0; no counter logic.

Decomposition:
- Package xadc_seq_pkg holds:
  - state encoding: INIT, WAIT_EOS, WAIT_DRDY, PUBLISH;
  - DRP address constants: ADDR_VPVN=7'h03, ADDR_VAUX0=7'h10, ADDR_VAUX8=7'h18, ADDR_CFG0=7'h40;
  - the format function for the SAMPLE_W=12 slice.
- No sub-module; the decimation counter and shadow registers are small enough to stay inline.

Test Plan:
- Defaults, BFM XADC DRDY 3 cycles after DEN; DO=16'hA5A0 at 7'h10 and 16'h5A50 at 7'h18; EOS pulse:
  - DEN at 7'h10 one cycle after EOS, then DEN at 7'h18;
  - FIFO_EN one cycle after the second DRDY;
  - SAMPLES=32'h5A50A5A0.
- NUM_CH=4, CH_ADDRS={7'h1B,7'h13,7'h03,7'h11}, SAMPLE_W=12:
  - four DEN pulses in list order;
  - slot i equals BFM DO[15:4] for its address.
- DECIM=3, six EOS frames:
  - FIFO_EN on frames 3 and 6 only;
  - SAMPLES changes only at those strobes.
- Second EOS during WAIT_DRDY:
  - OVERRUN=1;
  - the next frame's DEN one cycle after PUBLISH;
  - CLR_FLAGS returns OVERRUN to 0.
- RESET_N low between the two DEN pulses:
  - outputs zero, stray DRDY ignored;
  - after release, INIT waits for BUSY=0; the next EOS gives a clean frame.
- XADC_SEQ_DRDY_TIMEOUT_EN, TIMEOUT_CYC=16, BFM withholds DRDY:
  - TIMEOUT=1 after 16 cycles, no FIFO_EN;
  - the next EOS frame publishes normally.
